seg_scan_mux: RTL and testbench

Parametrised multiplexed seven-segment scan controller. It drives NUM_DIGITS common-anode/cathode digits from a packed hex value, with per-digit decimal point and blanking, leading-zero suppression, PWM brightness, and tear-free double-buffered updates. It sits between application logic and the board's segment/digit-enable pins, and replaces the fixed single-digit display driver.

---
 rtl/seg_pkg.sv | 56 +++++
 rtl/seg_scan_mux_if.sv | 22 ++
 rtl/seg_hex_decode.sv | 12 +
 rtl/seg_scan_mux.sv | 168 ++++++++++++++++
 tb/tb_seg_scan_mux.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: segment bit
// positions, hex glyphs and the nibble-to-glyph function.
package seg_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    typedef logic [6:0] glyph_t;

    localparam glyph_t GLYPH_0 = 7'h3F;
    localparam glyph_t GLYPH_1 = 7'h06;
    localparam glyph_t GLYPH_2 = 7'h5B;
    localparam glyph_t GLYPH_3 = 7'h4F;
    localparam glyph_t GLYPH_4 = 7'h66;
    localparam glyph_t GLYPH_5 = 7'h6D;
    localparam glyph_t GLYPH_6 = 7'h7D;
    localparam glyph_t GLYPH_7 = 7'h07;
    localparam glyph_t GLYPH_8 = 7'h7F;
    localparam glyph_t GLYPH_9 = 7'h6F;
    localparam glyph_t GLYPH_A = 7'h77;
    localparam glyph_t GLYPH_B = 7'h7C;
    localparam glyph_t GLYPH_C = 7'h39;
    localparam glyph_t GLYPH_D = 7'h5E;
    localparam glyph_t GLYPH_E = 7'h79;
    localparam glyph_t GLYPH_F = 7'h71;

    function automatic glyph_t hex_to_seg(input logic [3:0] nib);
        glyph_t g;
        case (nib)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Update bus from application logic into the scan controller: the load
// strobe with its captured fields, and the pending flag coming back.
interface seg_scan_mux_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [NUM_DIGITS-1:0]     blank_in;
    logic                      lz_suppress;
    logic                      pending;

    modport master (
        output load, value_in, dp_in, blank_in, lz_suppress,
        input  pending
    );

    modport slave (
        input  load, value_in, dp_in, blank_in, lz_suppress,
        output pending
    );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble to a..g decoder, active-high; polarity is applied
// only at the output register of the scan controller.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = hex_to_seg(nibble_i);
    end
endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scan controller with leading-zero suppression,
// PWM dimming and a pending/active buffer pair swapped at the frame boundary.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned CLK_DIV_LOG2    = 4,
    parameter int unsigned DIM_BITS        = 2,
    parameter int unsigned SEG_ACTIVE_HIGH = 1,
    parameter int unsigned EN_ACTIVE_HIGH  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    seg_scan_mux_if.slave         bus,
    input  logic [DIM_BITS-1:0]   brightness,
    output logic [7:0]            segment_out,
    output logic [NUM_DIGITS-1:0] enable_out,
    output logic                  frame_done
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = (EN_ACTIVE_HIGH != 0) ? '0 : '1;

    logic [CLK_DIV_LOG2-1:0]  div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]         digit_idx_q, digit_idx_d;
    logic                     slot_end, frame_end;

    logic [4*NUM_DIGITS-1:0]  pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]    pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]    pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                     pend_lz_q, pend_lz_d, act_lz_q, act_lz_d;
    logic                     pending_q, pending_d;

    logic [NUM_DIGITS-1:0]    lz_mask;
    logic                     zero_run;
    logic [3:0]               cur_nib;
    logic [6:0]               cur_glyph;
    logic [7:0]               seg_raw;
    logic                     slot_on;
    logic [NUM_DIGITS-1:0]    en_raw;

    logic [7:0]               seg_q, seg_d;
    logic [NUM_DIGITS-1:0]    en_q, en_d;
    logic                     frame_done_q, frame_done_d;

    always_comb begin
        slot_end    = (div_cnt_q == '1);
        frame_end   = slot_end && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
        div_cnt_d   = div_cnt_q + CLK_DIV_LOG2'(1);
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = frame_end ? '0 : digit_idx_q + IDX_W'(1);
        end
    end

    // A load landing on the boundary edge bypasses the pending set entirely.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_lz_d    = pend_lz_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        act_lz_d     = act_lz_q;
        pending_d    = pending_q;
        if (bus.load && frame_end) begin
            act_val_d   = bus.value_in;
            act_dp_d    = bus.dp_in;
            act_blank_d = bus.blank_in;
            act_lz_d    = bus.lz_suppress;
            pending_d   = 1'b0;
        end else begin
            if (frame_end && pending_q) begin
                act_val_d   = pend_val_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
                act_lz_d    = pend_lz_q;
                pending_d   = 1'b0;
            end
            if (bus.load) begin
                pend_val_d   = bus.value_in;
                pend_dp_d    = bus.dp_in;
                pend_blank_d = bus.blank_in;
                pend_lz_d    = bus.lz_suppress;
                pending_d    = 1'b1;
            end
        end
    end

    // Walk from the most significant digit down, tracking an unbroken zero run.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            zero_run = zero_run && (act_val_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
            lz_mask[NUM_DIGITS-1-j] = act_lz_q && zero_run && (j != NUM_DIGITS - 1);
        end
    end

    always_comb begin
        cur_nib = act_val_q[digit_idx_q*4 +: 4];
    end

    seg_hex_decode u_dec (
        .nibble_i (cur_nib),
        .seg_o    (cur_glyph)
    );

    always_comb begin
        seg_raw = '0;
        if (!act_blank_q[digit_idx_q]) begin
            seg_raw[SEG_DP] = act_dp_q[digit_idx_q];
            if (!lz_mask[digit_idx_q]) begin
                seg_raw[SEG_G:SEG_A] = cur_glyph;
            end
        end
        seg_d = (SEG_ACTIVE_HIGH != 0) ? seg_raw : ~seg_raw;

        // div_cnt == 0 stays dark so the previous digit never ghosts into this one.
        slot_on = (div_cnt_q != '0) &&
                  (div_cnt_q[CLK_DIV_LOG2-1 -: DIM_BITS] <= brightness);
        en_raw  = slot_on ? (NUM_DIGITS'(1) << digit_idx_q) : '0;
        en_d    = (EN_ACTIVE_HIGH != 0) ? en_raw : ~en_raw;

        frame_done_d = (digit_idx_q == '0) && (div_cnt_q == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_lz_q    <= 1'b0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            act_lz_q     <= 1'b0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            en_q         <= EN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_lz_q    <= pend_lz_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_lz_q     <= act_lz_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            en_q         <= en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segment_out = seg_q;
    assign enable_out  = en_q;
    assign frame_done  = frame_done_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised scoreboard bench for seg_scan_mux; the reference model works per
// frame: each frame shows the last load issued before that frame began.
module tb_seg_scan_mux;
    localparam int ND    = 4;
    localparam int SLOT  = 16;
    localparam int FRAME = ND * SLOT;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  brightness;
    logic [7:0]  segment_out;
    logic [3:0]  enable_out;
    logic        frame_done;

    seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_mux #(
        .NUM_DIGITS      (ND),
        .CLK_DIV_LOG2    (4),
        .DIM_BITS        (2),
        .SEG_ACTIVE_HIGH (1),
        .EN_ACTIVE_HIGH  (0)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .brightness  (brightness),
        .segment_out (segment_out),
        .enable_out  (enable_out),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] en;
        logic       pend;
        logic       fd;
        int         k;
    } exp_t;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        int          j;
    } set_t;

    exp_t sb[$];
    set_t shown, latest;
    int   k;
    int   checks = 0;
    int   passed = 0;
    logic [1:0] bright_sel;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input int at, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s k=%0d: got %h expected %h", name, at, act, exp);
    endtask

    function automatic logic [7:0] digit_seg(input set_t s, input int d);
        logic [15:0] upper;
        logic [3:0]  nib;
        upper = s.val >> (4 * d);
        nib   = upper[3:0];
        if (s.blank[d]) return 8'h00;
        if (s.lz && d != 0 && upper == 16'h0) return {s.dp[d], 7'h00};
        return {s.dp[d], glyph[nib]};
    endfunction

    task automatic model_reset();
        shown  = '{val: 16'h0, dp: 4'h0, blank: 4'h0, lz: 1'b0, j: -1};
        latest = shown;
        k      = 0;
    endtask

    // Drives the inputs sampled by edge k and queues what that edge must produce.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] dp,
                        input logic [3:0] blank, input logic lz);
        exp_t e;
        int   d, dv, bnd;
        @(negedge clock);
        brightness      = bright_sel;
        bus.load        = ld;
        bus.value_in    = ld ? v     : 16'($urandom);
        bus.dp_in       = ld ? dp    : 4'($urandom);
        bus.blank_in    = ld ? blank : 4'($urandom);
        bus.lz_suppress = ld ? lz    : 1'($urandom);
        if (k % FRAME == 0 && k > 0) shown = latest;
        if (ld) latest = '{val: v, dp: dp, blank: blank, lz: lz, j: k};
        bnd    = ((k + 1) / FRAME) * FRAME - 1;
        dv     = k % SLOT;
        d      = (k / SLOT) % ND;
        e.seg  = digit_seg(shown, d);
        e.en   = (dv != 0 && dv / 4 <= int'(bright_sel)) ? ~(4'b0001 << d) : 4'hF;
        e.pend = latest.j > bnd;
        e.fd   = (k % FRAME == 0);
        e.k    = k;
        sb.push_back(e);
        k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_seg"},  k, 32'(segment_out), 32'h00);
        check({tag, "_en"},   k, 32'(enable_out),  32'hF);
        check({tag, "_pend"}, k, 32'(bus.pending), 32'h0);
        check({tag, "_fd"},   k, 32'(frame_done),  32'h0);
    endtask

    task automatic mid_slot_reset();
        while (k % SLOT != 7) idle(1);
        @(posedge clock);
        #5;
        reset_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        sb.delete();
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset_n && sb.size() > 0) begin
                e = sb.pop_front();
                check("seg",        e.k, 32'(segment_out), 32'(e.seg));
                check("enable",     e.k, 32'(enable_out),  32'(e.en));
                check("pending",    e.k, 32'(bus.pending), 32'(e.pend));
                check("frame_done", e.k, 32'(frame_done),  32'(e.fd));
            end
        end
    end

    initial begin : stimulus
        bus.load        = 1'b0;
        bus.value_in    = '0;
        bus.dp_in       = '0;
        bus.blank_in    = '0;
        bus.lz_suppress = 1'b0;
        bright_sel      = 2'd3;
        brightness      = 2'd3;
        model_reset();
        #12;
        check_reset_state("rst_init");
        @(posedge clock);
        #3;
        reset_n = 1'b1;

        idle(FRAME);
        idle(10);
        step(1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
        idle(2 * FRAME);

        bright_sel = 2'd0; idle(FRAME);
        bright_sel = 2'd1; idle(FRAME);
        bright_sel = 2'd3;

        step(1'b1, 16'h0050, 4'h0, 4'h0, 1'b1); idle(2 * FRAME);
        step(1'b1, 16'h0000, 4'h0, 4'h0, 1'b1); idle(2 * FRAME);

        while (k % FRAME != 20) idle(1);
        step(1'b1, 16'h1111, 4'h0, 4'h0, 1'b0);
        idle(2 * FRAME);
        step(1'b1, 16'h2345, 4'h0, 4'h0, 1'b0);
        idle(5);
        step(1'b1, 16'hC0DE, 4'h3, 4'h0, 1'b0);
        idle(2 * FRAME);

        while (k % FRAME != FRAME - 1) idle(1);
        step(1'b1, 16'hBEEF, 4'h0, 4'h0, 1'b0);
        idle(FRAME + 16);

        step(1'b1, 16'h89AB, 4'b0100, 4'b1000, 1'b0);
        idle(2 * FRAME);

        mid_slot_reset();
        idle(FRAME + 8);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) bright_sel = 2'($urandom);
            if ($urandom_range(0, 39) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            else if ($urandom_range(0, 149) == 0)
                step(1'b1, 16'($urandom_range(0, 255)), 4'($urandom), 4'h0, 1'b1);
            else
                idle(1);
        end

        @(posedge clock);
        #3;
        check("scoreboard_drained", k, 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
